// File: rtl/msrv32_pkg.sv
// msrv32_pkg: state encodings, next-PC selects and trap cause codes for machine control
package msrv32_pkg;
  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } state_t;
  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;
  localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_INT       = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_INT    = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_INT      = 4'd11;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam logic [6:0] F7_MRET    = 7'b0011000;
endpackage

// File: rtl/msrv32_machine_control_if.sv
// msrv32_machine_control_if: decoder/CSR-facing signals of the machine control block
interface msrv32_machine_control_if;
  logic       illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic [1:0] pc_src_out;
  logic       flush_out, trap_taken_out, i_or_e_out, set_cause_out, set_epc_out;
  logic       mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out;
  logic [3:0] cause_out;
  modport master (
    output illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
           opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    input  pc_src_out, flush_out, trap_taken_out, i_or_e_out, set_cause_out, set_epc_out,
           mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out, cause_out
  );
  modport slave (
    input  illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
           opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    output pc_src_out, flush_out, trap_taken_out, i_or_e_out, set_cause_out, set_epc_out,
           mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out, cause_out
  );
endinterface

// File: rtl/msrv32_trap_prioritizer.sv
// msrv32_trap_prioritizer: SYSTEM decode plus exception/interrupt priority and cause encoding
module msrv32_trap_prioritizer
  import msrv32_pkg::*;
(
  input  logic       illegal_i,
  input  logic       misaligned_instr_i,
  input  logic       misaligned_load_i,
  input  logic       misaligned_store_i,
  input  logic [4:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       mie_i,
  input  logic       meie_i,
  input  logic       mtie_i,
  input  logic       msie_i,
  input  logic       meip_i,
  input  logic       mtip_i,
  input  logic       msip_i,
  output logic       exc_o,
  output logic       irq_o,
  output logic       is_mret_o,
  output logic [3:0] cause_o,
  output logic       i_or_e_o
);
  logic sys, is_ecall, is_ebreak, ext, sw, tm;
  logic [3:0] exc_cause, irq_cause;
  always_comb begin
    sys       = opcode_i == OPC_SYSTEM && funct3_i == 3'b000 && rs1_i == 5'd0 && rd_i == 5'd0;
    is_ecall  = sys && funct7_i == 7'd0 && rs2_i == 5'd0;
    is_ebreak = sys && funct7_i == 7'd0 && rs2_i == 5'd1;
    is_mret_o = sys && funct7_i == F7_MRET && rs2_i == 5'd2;
    ext       = meie_i & meip_i;
    sw        = msie_i & msip_i;
    tm        = mtie_i & mtip_i;
    exc_o     = illegal_i | misaligned_instr_i | misaligned_load_i | misaligned_store_i | is_ecall | is_ebreak;
    irq_o     = mie_i & (ext | sw | tm);
    exc_cause = illegal_i ? CAUSE_ILLEGAL : misaligned_instr_i ? CAUSE_INSTR_MISALIGN :
                is_ecall ? CAUSE_ECALL_M : is_ebreak ? CAUSE_BREAKPOINT :
                misaligned_load_i ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
    irq_cause = ext ? CAUSE_M_EXT_INT : sw ? CAUSE_M_SW_INT : CAUSE_M_TIMER_INT;
    cause_o   = exc_o ? exc_cause : irq_cause;
    i_or_e_o  = !exc_o && irq_o;
  end
endmodule

// File: rtl/msrv32_machine_control.sv
// msrv32_machine_control: machine-mode trap entry/return FSM driving next-PC select and CSR strobes
module msrv32_machine_control
  import msrv32_pkg::*;
(
  input logic ms_riscv32_mp_clk_in,
  input logic ms_riscv32_mp_rst_in,
  msrv32_machine_control_if.slave bus
);
  state_t state_q, state_d;
  logic [3:0] cause_q, cause;
  logic i_or_e_q, mis_q, exc, irq, is_mret, i_or_e, trap;
  msrv32_trap_prioritizer u_prio (
    .illegal_i(bus.illegal_instr_in), .misaligned_instr_i(bus.misaligned_instr_in),
    .misaligned_load_i(bus.misaligned_load_in), .misaligned_store_i(bus.misaligned_store_in),
    .opcode_i(bus.opcode_6_to_2_in), .funct3_i(bus.funct3_in), .funct7_i(bus.funct7_in),
    .rs1_i(bus.rs1_addr_in), .rs2_i(bus.rs2_addr_in), .rd_i(bus.rd_addr_in),
    .mie_i(bus.mie_in), .meie_i(bus.meie_in), .mtie_i(bus.mtie_in), .msie_i(bus.msie_in),
    .meip_i(bus.meip_in), .mtip_i(bus.mtip_in), .msip_i(bus.msip_in),
    .exc_o(exc), .irq_o(irq), .is_mret_o(is_mret), .cause_o(cause), .i_or_e_o(i_or_e)
  );
  assign trap = state_q == ST_OPERATING && (exc || irq);
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q  <= ST_RESET;
      cause_q  <= 4'd0;
      i_or_e_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (trap) begin
        cause_q  <= cause;
        i_or_e_q <= i_or_e;
        mis_q    <= !i_or_e && (cause == CAUSE_INSTR_MISALIGN || cause == CAUSE_LOAD_MISALIGN ||
                                cause == CAUSE_STORE_MISALIGN);
      end
    end
  end
  // MRET only returns when no trap competes for the same cycle
  always_comb begin
    state_d = ST_OPERATING;
    if (state_q == ST_OPERATING)
      state_d = trap ? ST_TRAP_TAKEN : is_mret ? ST_TRAP_RETURN : ST_OPERATING;
    bus.pc_src_out      = state_q == ST_OPERATING ? PC_NEXT : state_q == ST_TRAP_TAKEN ? PC_TRAP :
                          state_q == ST_TRAP_RETURN ? PC_EPC : PC_BOOT;
    bus.flush_out       = state_q != ST_OPERATING;
    bus.trap_taken_out  = trap;
    bus.instret_inc_out = state_q == ST_OPERATING && !trap;
    bus.set_cause_out   = state_q == ST_TRAP_TAKEN;
    bus.set_epc_out     = state_q == ST_TRAP_TAKEN;
    bus.mie_clear_out   = state_q == ST_TRAP_TAKEN;
    bus.mie_set_out     = state_q == ST_TRAP_RETURN;
  end
  assign bus.cause_out                = cause_q;
  assign bus.i_or_e_out               = i_or_e_q;
  assign bus.misaligned_exception_out = mis_q;
endmodule

// File: tb/tb_msrv32_machine_control.sv
// tb_msrv32_machine_control: per-cycle expected outputs queued at drive time, compared at negedge
module tb_msrv32_machine_control;
  typedef struct packed {
    logic [1:0] pc;
    logic       flush, tt, sc, se, mc, ms, inc, ioe, mis;
    logic [3:0] cause;
  } exp_t;
  typedef struct {
    string tag;
    exp_t  e;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rs1_bad = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  item_t sb[$];
  msrv32_machine_control_if bus ();
  msrv32_machine_control dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic exp_t mk(input logic [1:0] pc, input logic fl, tt, sc, ms, inc,
                              input logic [3:0] c, input logic i, m);
    return '{pc, fl, tt, sc, sc, sc, ms, inc, i, m, c};
  endfunction
  function automatic exp_t boot();
    return mk(2'b00, 1, 0, 0, 0, 0, 4'd0, 0, 0);
  endfunction
  function automatic exp_t op(input logic [3:0] c, input logic i, m);
    return mk(2'b11, 0, 0, 0, 0, 1, c, i, m);
  endfunction
  function automatic exp_t opt(input logic [3:0] c, input logic i, m);
    return mk(2'b11, 0, 1, 0, 0, 0, c, i, m);
  endfunction
  function automatic exp_t ttk(input logic [3:0] c, input logic i, m);
    return mk(2'b10, 1, 0, 1, 0, 0, c, i, m);
  endfunction
  function automatic exp_t trt(input logic [3:0] c, input logic i, m);
    return mk(2'b01, 1, 0, 0, 1, 0, c, i, m);
  endfunction
  // ex = {illegal, misaligned_instr, misaligned_load, misaligned_store}
  // sys: 0 none, 1 ecall, 2 ebreak, 3 mret
  // ir = {mie, meie, meip, msie, msip, mtie, mtip}
  task automatic cyc(input string tag, input logic r, input logic [3:0] ex, input logic [1:0] sys,
                     input logic [6:0] ir, input exp_t e);
    @(posedge clk);
    #1;
    rst = r;
    {bus.illegal_instr_in, bus.misaligned_instr_in, bus.misaligned_load_in, bus.misaligned_store_in} = ex;
    bus.opcode_6_to_2_in = sys != 2'd0 ? 5'b11100 : 5'b01100;
    bus.funct3_in        = 3'b000;
    bus.rs1_addr_in      = rs1_bad ? 5'd3 : 5'd0;
    bus.rd_addr_in       = 5'd0;
    bus.funct7_in        = sys == 2'd3 ? 7'b0011000 : 7'd0;
    bus.rs2_addr_in      = sys == 2'd3 ? 5'd2 : sys == 2'd2 ? 5'd1 : 5'd0;
    {bus.mie_in, bus.meie_in, bus.meip_in, bus.msie_in, bus.msip_in, bus.mtie_in, bus.mtip_in} = ir;
    sb.push_back('{tag, e});
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      check({it.tag, ".pc_src"}, 32'(bus.pc_src_out), 32'(it.e.pc));
      check({it.tag, ".flush"}, 32'(bus.flush_out), 32'(it.e.flush));
      check({it.tag, ".trap_taken"}, 32'(bus.trap_taken_out), 32'(it.e.tt));
      check({it.tag, ".set_cause"}, 32'(bus.set_cause_out), 32'(it.e.sc));
      check({it.tag, ".set_epc"}, 32'(bus.set_epc_out), 32'(it.e.se));
      check({it.tag, ".mie_clear"}, 32'(bus.mie_clear_out), 32'(it.e.mc));
      check({it.tag, ".mie_set"}, 32'(bus.mie_set_out), 32'(it.e.ms));
      check({it.tag, ".instret_inc"}, 32'(bus.instret_inc_out), 32'(it.e.inc));
      check({it.tag, ".i_or_e"}, 32'(bus.i_or_e_out), 32'(it.e.ioe));
      check({it.tag, ".mis_exc"}, 32'(bus.misaligned_exception_out), 32'(it.e.mis));
      check({it.tag, ".cause"}, 32'(bus.cause_out), 32'(it.e.cause));
    end
  end
  initial begin
    {bus.illegal_instr_in, bus.misaligned_instr_in, bus.misaligned_load_in, bus.misaligned_store_in} = 4'd0;
    bus.opcode_6_to_2_in = 5'd0;
    bus.funct3_in = 3'd0;
    bus.funct7_in = 7'd0;
    bus.rs1_addr_in = 5'd0;
    bus.rs2_addr_in = 5'd0;
    bus.rd_addr_in = 5'd0;
    {bus.mie_in, bus.meie_in, bus.meip_in, bus.msie_in, bus.msip_in, bus.mtie_in, bus.mtip_in} = 7'd0;
    cyc("rst_hold",    1, 4'b0000, 0, 7'b0000000, boot());
    cyc("rst_release", 0, 4'b0000, 0, 7'b0000000, boot());
    cyc("first_op",    0, 4'b0000, 0, 7'b0000000, op(0, 0, 0));
    cyc("illegal_det", 0, 4'b1000, 0, 7'b0000000, opt(0, 0, 0));
    cyc("illegal_tt",  0, 4'b0000, 0, 7'b0000000, ttk(2, 0, 0));
    cyc("illegal_ret", 0, 4'b0000, 0, 7'b0000000, op(2, 0, 0));
    cyc("irq_det",     0, 4'b0000, 0, 7'b1110011, opt(2, 0, 0));
    cyc("irq_tt",      0, 4'b0000, 0, 7'b0000000, ttk(11, 1, 0));
    cyc("irq_op",      0, 4'b0000, 0, 7'b0000000, op(11, 1, 0));
    cyc("irq_ld_det",  0, 4'b0010, 0, 7'b1110011, opt(11, 1, 0));
    cyc("irq_ld_tt",   0, 4'b0000, 0, 7'b0000000, ttk(4, 0, 1));
    cyc("irq_ld_op",   0, 4'b0000, 0, 7'b0000000, op(4, 0, 1));
    cyc("mret_det",    0, 4'b0000, 3, 7'b0000000, op(4, 0, 1));
    cyc("mret_tr",     0, 4'b0000, 0, 7'b0000000, trt(4, 0, 1));
    cyc("mret_op",     0, 4'b0000, 0, 7'b0000000, op(4, 0, 1));
    cyc("mret_ill",    0, 4'b1000, 3, 7'b0000000, opt(4, 0, 1));
    cyc("mret_ill_tt", 0, 4'b0000, 0, 7'b0000000, ttk(2, 0, 0));
    cyc("pre_rst_det", 0, 4'b1000, 0, 7'b0000000, opt(2, 0, 0));
    cyc("rst_in_tt",   1, 4'b0000, 0, 7'b0000000, ttk(2, 0, 0));
    cyc("after_rst",   0, 4'b0000, 0, 7'b0000000, boot());
    cyc("op_again",    0, 4'b0000, 0, 7'b0000000, op(0, 0, 0));
    cyc("ecall_det",   0, 4'b0000, 1, 7'b0000000, opt(0, 0, 0));
    cyc("ecall_tt",    0, 4'b0000, 0, 7'b0000000, ttk(11, 0, 0));
    cyc("ecall_op",    0, 4'b0000, 0, 7'b0000000, op(11, 0, 0));
    cyc("ebreak_det",  0, 4'b0000, 2, 7'b0000000, opt(11, 0, 0));
    cyc("ebreak_tt",   0, 4'b0000, 0, 7'b0000000, ttk(3, 0, 0));
    cyc("sw_tm_det",   0, 4'b0000, 0, 7'b1001111, opt(3, 0, 0));
    cyc("sw_tm_tt",    0, 4'b0000, 0, 7'b0000000, ttk(3, 1, 0));
    cyc("mi_ms_det",   0, 4'b0101, 0, 7'b0000000, opt(3, 1, 0));
    cyc("mi_ms_tt",    0, 4'b0000, 0, 7'b0000000, ttk(0, 0, 1));
    cyc("ms_det",      0, 4'b0001, 0, 7'b0000000, opt(0, 0, 1));
    cyc("ms_tt",       0, 4'b0000, 0, 7'b0000000, ttk(6, 0, 1));
    cyc("mie_off",     0, 4'b0000, 0, 7'b0110000, op(6, 0, 1));
    cyc("tm_det",      0, 4'b0000, 0, 7'b1000011, opt(6, 0, 1));
    cyc("tm_tt",       0, 4'b0000, 0, 7'b0000000, ttk(7, 1, 0));
    rs1_bad = 1'b1;
    cyc("ecall_rs1",   0, 4'b0000, 1, 7'b0000000, op(7, 1, 0));
    rs1_bad = 1'b0;
    cyc("b2b_det",     0, 4'b1000, 0, 7'b0000000, opt(7, 1, 0));
    cyc("b2b_tt",      0, 4'b1000, 0, 7'b0000000, ttk(2, 0, 0));
    cyc("b2b_det2",    0, 4'b1000, 0, 7'b0000000, opt(2, 0, 0));
    cyc("b2b_tt2",     0, 4'b0000, 0, 7'b0000000, ttk(2, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/msrv32_machine_control.md
MSRV32_MACHINE_CONTROL -- requirements
Module: msrv32_machine_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the clock port named ms_riscv32_mp_clk_in and the reset port named ms_riscv32_mp_rst_in.
REQ-002 ms_riscv32_mp_clk_in  in  1  clock; all state changes on the rising edge.
REQ-003 ms_riscv32_mp_rst_in  in  1  synchronous active-high reset.
REQ-004 illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in  in  1 each  exception flags from the decoder and fetch stages.
REQ-005 opcode_6_to_2_in  in  5 / funct3_in  in  3 / funct7_in  in  7 / rs1_addr_in, rs2_addr_in, rd_addr_in  in  5 each  instruction fields used for ECALL, EBREAK and MRET detection.
REQ-006 mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in  in  1 each  global enable, per-source enables and pending bits from the CSR file.
REQ-007 pc_src_out  out  2  selects the next PC: 00 boot, 01 epc, 10 trap vector, 11 next PC.
REQ-008 flush_out, trap_taken_out, i_or_e_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out  out  1 each  pipeline and CSR controls.
REQ-009 cause_out  out  4  registered trap cause code.

Function
REQ-010 FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN, 2-bit encoding.
- RESET -> OPERATING unconditionally on the next edge.
- TRAP_TAKEN -> OPERATING unconditionally.
- TRAP_RETURN -> OPERATING unconditionally.
REQ-011 OPERATING -> TRAP_TAKEN when exc or irq is true; else -> TRAP_RETURN when is_mret; else stay.
- exc = illegal | misaligned_instr | misaligned_load | misaligned_store | is_ecall | is_ebreak.
- irq = mie_in & ((meie_in&meip_in) | (msie_in&msip_in) | (mtie_in&mtip_in)).
REQ-012 Decodes, all with opcode_6_to_2_in=11100, funct3_in=000, rs1=0, rd=0:
- is_ecall: funct7=0000000, rs2=00000.
- is_ebreak: funct7=0000000, rs2=00001.
- is_mret: funct7=0011000, rs2=00010.
REQ-013 When exc and irq coincide, the exception wins and i_or_e_out is 0.
REQ-014 Exception priority and cause codes: illegal 2 > misaligned_instr 0 > ecall 11 > ebreak 3 > misaligned_load 4 > misaligned_store 6.
REQ-015 Interrupt priority and cause codes: external 11 > software 3 > timer 7.
REQ-016 On the OPERATING -> TRAP_TAKEN edge, the block SHALL register cause_out, i_or_e_out (1 for interrupt), and misaligned_exception_out (1 only for cause 0, 4 or 6 with i_or_e 0). These hold until the next trap entry or reset.
REQ-017 trap_taken_out SHALL be combinational and asserted in OPERATING in the same cycle the trap condition is true, so that the same-cycle memory write is suppressed.
REQ-018 An MRET that coincides with exc or irq SHALL be treated as a trap; TRAP_RETURN is not entered.
REQ-019 Outputs by state:
- RESET: pc_src=00, flush=1, all strobes 0.
- OPERATING: pc_src=11, flush=0, instret_inc_out=1 only when no trap is being taken.
- TRAP_TAKEN: pc_src=10, flush=1, set_cause_out=set_epc_out=mie_clear_out=1 for exactly one cycle.
- TRAP_RETURN: pc_src=01, flush=1, mie_set_out=1 for exactly one cycle.
REQ-020 Trap entry latency SHALL be one cycle from condition detection to the pc_src=10 cycle, and back-to-back traps SHALL be separated by at least one OPERATING cycle.

Reset
REQ-021 Reset values: state RESET, pc_src_out=00, flush_out=1, cause_out=0, i_or_e_out=0, misaligned_exception_out=0, all other outputs 0.
REQ-022 Reset asserted in any state, including TRAP_TAKEN or TRAP_RETURN, SHALL force RESET on the next edge and discard any pending trap.

Structure
REQ-023 Package msrv32_pkg SHALL hold the state encodings, pc_src codes and all cause-code constants.
REQ-024 Priority and cause encoding SHALL live in the combinational sub-module msrv32_trap_prioritizer, which outputs exc, irq, cause and i_or_e; the FSM and registers stay in msrv32_machine_control.

Verification
REQ-025 Reset release -> one cycle of pc_src=00 with flush=1, then pc_src=11, flush=0, instret_inc=1.
REQ-026 illegal_instr_in=1 for one cycle in OPERATING -> trap_taken=1 that cycle; next cycle pc_src=10, cause=2, i_or_e=0, set_cause=set_epc=mie_clear=1; the cycle after returns to OPERATING.
REQ-027 mie_in=1, meie=meip=1, mtie=mtip=1 -> cause=11, i_or_e=1; with additionally misaligned_load_in=1 -> cause=4, i_or_e=0, misaligned_exception_out=1.
REQ-028 MRET fields (funct7=0011000, rs2=00010) with no trap -> pc_src=01, mie_set=1 for one cycle, then pc_src=11; the same with illegal_instr_in=1 -> TRAP_TAKEN with cause 2.
REQ-029 Reset asserted in TRAP_TAKEN -> next cycle state RESET, pc_src=00, cause=0, no set_cause pulse.
